mem_arbiter: RTL

- Sits directly downstream of the instruction cache and beside the data cache.
- Arbitrates icache fill reads and dcache reads/writes onto the single RAM port.
- Returns the per-requester wait and load signals that the caches consume.
- Registered-grant FSM with optional fairness, stall until RAM ACCESS, and a saturating RAM error counter.

---
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the single RAM port.
// The arbiter takes the slave view; caches and RAM model take the master view.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Registered-grant arbiter putting icache fills and dcache reads/writes onto
// one RAM port; outputs are combinational from state and live inputs.
module mem_arbiter #(
    parameter bit FAIR   = 1'b1,
    parameter int ECNT_W = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    mem_arbiter_if.slave      bus,
    output logic [ECNT_W-1:0] err_cnt
);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_t;

    state_t            r_state, w_next;
    logic              r_last_d, w_last_d_next;
    logic [ECNT_W-1:0] r_err_cnt;
    logic              w_err;
    logic              w_ireq, w_dreq;

    assign w_ireq  = bus.iREN;
    assign w_dreq  = bus.dREN | bus.dWEN;
    assign err_cnt = r_err_cnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_last_d <= w_last_d_next;
            if (w_err && (r_err_cnt != {ECNT_W{1'b1}}))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_last_d_next = r_last_d;
        w_err         = 1'b0;
        bus.iwait     = 1'b1;
        bus.dwait     = 1'b1;
        bus.iload     = '0;
        bus.dload     = '0;
        bus.ramREN    = 1'b0;
        bus.ramWEN    = 1'b0;
        bus.ramaddr   = '0;
        bus.ramstore  = '0;
        case (r_state)
            IDLE: begin
                if (w_ireq && w_dreq)
                    w_next = (FAIR && r_last_d) ? ISERV : DSERV;
                else if (w_dreq)
                    w_next = DSERV;
                else if (w_ireq)
                    w_next = ISERV;
            end
            ISERV: begin
                bus.ramaddr = bus.iaddr;
                // A dropped iREN abandons the fetch even if RAM reports ACCESS.
                if (!bus.iREN) begin
                    w_next = IDLE;
                end else begin
                    bus.ramREN = 1'b1;
                    if (bus.ramstate == RS_ACCESS) begin
                        bus.iwait     = 1'b0;
                        bus.iload     = bus.ramload;
                        w_next        = IDLE;
                        w_last_d_next = 1'b0;
                    end else if (bus.ramstate == RS_ERROR) begin
                        w_err = 1'b1;
                    end
                end
            end
            DSERV: begin
                bus.ramaddr = bus.daddr;
                if (!w_dreq) begin
                    w_next = IDLE;
                end else begin
                    if (bus.dWEN) begin
                        bus.ramWEN   = 1'b1;
                        bus.ramstore = bus.dstore;
                    end else begin
                        bus.ramREN = 1'b1;
                    end
                    if (bus.ramstate == RS_ACCESS) begin
                        bus.dwait     = 1'b0;
                        bus.dload     = bus.dWEN ? 32'd0 : bus.ramload;
                        w_next        = IDLE;
                        w_last_d_next = 1'b1;
                    end else if (bus.ramstate == RS_ERROR) begin
                        w_err = 1'b1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end
endmodule
